tmac_dot_sequencer: RTL

//   Sequences one traditionalMac PE through a dot-product job: clears the accumulator, streams
//   vec_len (weight, activation) pairs from an upstream buffer, then returns the 21-bit sum
//   on a valid/ready result port. Sits between the operand buffer and the MAC PE. One job in flight.

---
 rtl/tmac_dot_sequencer.sv | 118 +++++++++++
 1 files changed

// File: rtl/tmac_dot_sequencer.sv
// Dot-product job sequencer for one traditionalMac PE.
// Clears the PE accumulator, streams vec_len_i (weight, activation) pairs
// from the operand buffer into the PE, then presents the signed sum on a
// valid/ready result port. Only one job is in flight at a time.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   start_i, vec_len_i         job request and length (sampled only in IDLE)
//   busy_o                     high whenever a job is in progress
//   in_valid_i/in_ready_o      operand-pair handshake (ready only while accumulating)
//   in_weight_i, in_act_i      signed operand pair
//   mac_*_o                    PE control and operands (decoded from state)
//   mac_result_i               PE accumulator output
//   res_valid_o/res_ready_i    result handshake; res_data_o held until accepted
//   res_data_o                 registered signed dot-product result
module tmac_dot_sequencer #(
    parameter int unsigned LEN_W = 10,
    parameter int unsigned W_W   = 4,
    parameter int unsigned A_W   = 8,
    parameter int unsigned ACC_W = 21
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [LEN_W-1:0]        vec_len_i,
    output logic                    busy_o,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic signed [W_W-1:0]   in_weight_i,
    input  logic signed [A_W-1:0]   in_act_i,
    output logic                    mac_en_o,
    output logic                    mac_reset_o,
    output logic                    mac_data_valid_o,
    output logic signed [W_W-1:0]   mac_weight_o,
    output logic signed [A_W-1:0]   mac_act_o,
    input  logic signed [ACC_W-1:0] mac_result_i,
    output logic                    res_valid_o,
    input  logic                    res_ready_i,
    output logic signed [ACC_W-1:0] res_data_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_ACC  = 3'd2,
        S_WAIT = 3'd3,
        S_OUT  = 3'd4
    } state_e;

    state_e                    state_q;
    logic [LEN_W-1:0]          len_q;
    logic [LEN_W-1:0]          cnt_q;
    logic                      res_valid_q;
    logic signed [ACC_W-1:0]   res_data_q;
    logic                      handshake;

    assign handshake = (state_q == S_ACC) && in_valid_i;

    // Job sequencing, beat counting and result capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        len_q   <= vec_len_i;
                        cnt_q   <= '0;
                        state_q <= S_CLR;
                    end
                end
                S_CLR: begin
                    // Zero-length jobs skip straight to the result; the PE was just cleared.
                    state_q <= (len_q != '0) ? S_ACC : S_WAIT;
                end
                S_ACC: begin
                    if (in_valid_i) begin
                        cnt_q <= cnt_q + LEN_W'(1);
                        if (cnt_q == len_q - LEN_W'(1)) begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // PE register now holds the final beat's contribution.
                    res_data_q  <= mac_result_i;
                    res_valid_q <= 1'b1;
                    state_q     <= S_OUT;
                end
                S_OUT: begin
                    if (res_ready_i) begin
                        res_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // PE-facing controls decode from state; operands pass through only on a handshake
    assign busy_o           = (state_q != S_IDLE);
    assign in_ready_o       = (state_q == S_ACC);
    assign mac_en_o         = (state_q == S_CLR) || (state_q == S_ACC);
    assign mac_reset_o      = (state_q == S_CLR);
    assign mac_data_valid_o = handshake;
    assign mac_weight_o     = handshake ? in_weight_i : '0;
    assign mac_act_o        = handshake ? in_act_i : '0;
    assign res_valid_o      = res_valid_q;
    assign res_data_o       = res_data_q;

endmodule
